// File: rtl/mgt_01_booth_multiplier_if.sv
// Request/result bundle for the iterative Booth multiplier.
interface mgt_01_booth_multiplier_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] multiplicand_i;
  logic [XLEN-1:0] multiplier_i;
  logic [XLEN-1:0] product_o;
  logic            valid_o;
  logic            busy_o;

  modport master (
    output start_i, op_i, multiplicand_i, multiplier_i,
    input  product_o, valid_o, busy_o
  );

  modport slave (
    input  start_i, op_i, multiplicand_i, multiplier_i,
    output product_o, valid_o, busy_o
  );
endinterface

// File: rtl/mgt_01_booth_multiplier.sv
// Iterative radix-2 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Optional MGT_01_MUL_ZERO_SKIP_EN: a zero operand bypasses the iteration loop.
//
// state    | meaning
// IDLE     | waiting for start_i
// MULTIPLY | one Booth step per enabled cycle, counter 0..XLEN
// FINALIZE | select product half into the result register
// VALID    | result strobe for one enabled cycle
module mgt_01_booth_multiplier #(
  parameter int XLEN = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          clk_en_i,
  mgt_01_booth_multiplier_if.slave      bus
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULTIPLY = 2'd1,
    FINALIZE = 2'd2,
    VALID    = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN+1:0] p;
  logic [XLEN:0]   a;
  logic            q_m1;
  logic [XLEN:0]   mcand;
  logic [1:0]      op_q;
  logic [XLEN-1:0] product_q;
  logic            valid_q;
  logic            busy_q;

  logic [XLEN:0]     mcand_ext_in;
  logic [XLEN:0]     mplier_ext_in;
  logic [XLEN+1:0]   mcand_wide;
  logic [XLEN+1:0]   p_sum;
  logic [2*XLEN-1:0] prod_full;

  // MULHU treats rs1 as unsigned; MULHSU and MULHU treat rs2 as unsigned.
  assign mcand_ext_in  = {(bus.op_i != 2'b11) & bus.multiplicand_i[XLEN-1], bus.multiplicand_i};
  assign mplier_ext_in = {~bus.op_i[1] & bus.multiplier_i[XLEN-1], bus.multiplier_i};
  assign mcand_wide    = {mcand[XLEN], mcand};
  assign prod_full     = {p[XLEN-2:0], a};

  always_comb begin
    p_sum = p;
    case ({a[0], q_m1})
      2'b01:   p_sum = p + mcand_wide;
      2'b10:   p_sum = p - mcand_wide;
      default: p_sum = p;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      cnt       <= '0;
      p         <= '0;
      a         <= '0;
      q_m1      <= 1'b0;
      mcand     <= '0;
      op_q      <= 2'b00;
      product_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else if (clk_en_i) begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            mcand  <= mcand_ext_in;
            op_q   <= bus.op_i;
            p      <= '0;
            a      <= mplier_ext_in;
            q_m1   <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
`ifdef MGT_01_MUL_ZERO_SKIP_EN
            if ((bus.multiplicand_i == '0) || (bus.multiplier_i == '0)) begin
              a     <= '0;
              state <= FINALIZE;
            end else begin
              state <= MULTIPLY;
            end
`else
            state  <= MULTIPLY;
`endif
          end
        end
        MULTIPLY: begin
          p    <= {p_sum[XLEN+1], p_sum[XLEN+1:1]};
          a    <= {p_sum[0], a[XLEN:1]};
          q_m1 <= a[0];
          if (cnt == CW'(XLEN)) begin
            cnt   <= '0;
            state <= FINALIZE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINALIZE: begin
          product_q <= (op_q == 2'b00) ? prod_full[XLEN-1:0] : prod_full[2*XLEN-1:XLEN];
          valid_q   <= 1'b1;
          state     <= VALID;
        end
        VALID: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.product_o = product_q;
  assign bus.valid_o   = valid_q;
  assign bus.busy_o    = busy_q;

endmodule
